// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the binary-to-one-hot decoder.
package decoder_pkg;

    localparam int unsigned DEFAULT_IN_W = 2;
    localparam int unsigned MAX_OUT_W    = 64;

    // Disabled-state pattern: all zeros, or the low out_w bits set when active-low.
    function automatic logic [MAX_OUT_W-1:0] disabled_value(input int unsigned out_w,
                                                            input bit          active_low);
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        if (active_low) begin
            for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
                if (i < out_w) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational binary-to-one-hot core; output is all zeros when disabled.
module decoder_core #(
    parameter int unsigned IN_W = 2
) (
    input  logic [IN_W-1:0]      i_sel,
    input  logic                 i_en,
    output logic [(2**IN_W)-1:0] o_raw
);

    always_comb begin
        o_raw = '0;
        // i_sel is only looked at when enabled, so X/Z on it cannot leak out while idle.
        if (i_en) o_raw[i_sel] = 1'b1;
    end

endmodule

// File: rtl/decoder.sv
// Decoder top: polarity inversion and optional output register around decoder_core.
module decoder
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W           = DEFAULT_IN_W,
    parameter bit          OUT_ACTIVE_LOW = 1'b0,
    parameter bit          REG_OUT        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      in,
    input  logic                 en,
    output logic [(2**IN_W)-1:0] out,
    output logic                 out_vld
);

    localparam int unsigned       OUT_W = 2**IN_W;
    localparam logic [OUT_W-1:0]  DIS   = OUT_W'(disabled_value(OUT_W, OUT_ACTIVE_LOW));

    logic [OUT_W-1:0] w_raw;
    logic [OUT_W-1:0] w_pol;

    decoder_core #(
        .IN_W (IN_W)
    ) u_core (
        .i_sel (in),
        .i_en  (en),
        .o_raw (w_raw)
    );

    assign w_pol = OUT_ACTIVE_LOW ? ~w_raw : w_raw;

    if (REG_OUT) begin : g_reg
        logic [OUT_W-1:0] r_out;
        logic             r_vld;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out <= DIS;
                r_vld <= 1'b0;
            end else begin
                r_out <= w_pol;
                r_vld <= en;
            end
        end

        assign out     = r_out;
        assign out_vld = r_vld;
    end else begin : g_comb
        // Clock and reset are intentionally inert in the combinational build.
        logic w_unused;
        assign w_unused = clk ^ rst;
        assign out      = w_pol;
        assign out_vld  = en;
    end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench: registered default and active-low builds, plus a 3-bit combinational build.
module tb_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [1:0] in2 = '0;
    logic       en2 = 1'b0;
    logic [3:0] out_d, out_a;
    logic       vld_d, vld_a;
    logic [2:0] in3 = '0;
    logic       en3 = 1'b0;
    logic [7:0] out_c;
    logic       vld_c;

    decoder u_def (
        .clk(clk), .rst(rst), .in(in2), .en(en2), .out(out_d), .out_vld(vld_d)
    );

    decoder #(.IN_W(2), .OUT_ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) u_al (
        .clk(clk), .rst(rst), .in(in2), .en(en2), .out(out_a), .out_vld(vld_a)
    );

    decoder #(.IN_W(3), .OUT_ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) u_cmb (
        .clk(clk), .rst(rst), .in(in3), .en(en3), .out(out_c), .out_vld(vld_c)
    );

    typedef struct {
        logic [3:0] out_d;
        logic [3:0] out_a;
        logic       vld;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: a disabled decoder shows nothing; an enabled one lights line number sel.
    function automatic exp_t model(input logic [1:0] sel, input bit e);
        exp_t r;
        r.out_d = 4'b0000;
        if (e) r.out_d = 4'(1 << int'(sel));
        r.out_a = ~r.out_d;
        r.vld   = e;
        return r;
    endfunction

    function automatic logic [7:0] model8(input logic [2:0] sel, input bit e);
        return e ? 8'(1 << int'(sel)) : 8'h00;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("reg_out",    64'(out_d), 64'(e.out_d));
            check("reg_vld",    64'(vld_d), 64'(e.vld));
            check("al_out",     64'(out_a), 64'(e.out_a));
            check("al_vld",     64'(vld_a), 64'(e.vld));
        end
    end

    task automatic drive(input logic [1:0] i, input bit e, input logic [2:0] ic, input bit ec);
        @(negedge clk);
        in2 = i;
        en2 = e;
        in3 = ic;
        en3 = ec;
        q.push_back(model(i, e));
        #1;
        check("comb_out", 64'(out_c), 64'(model8(ic, ec)));
        check("comb_vld", 64'(vld_c), 64'(ec));
        if (ec) check("comb_onehot", 64'($onehot(out_c)), 64'd1);
    endtask

    initial begin
        logic [1:0] ri;
        logic [2:0] rc;
        bit         re, rec;

        in2 = 2'd2;
        en2 = 1'b1;
        in3 = 3'd5;
        en3 = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_out",      64'(out_d), 64'h0);
        check("rst_vld",      64'(vld_d), 64'h0);
        check("rst_al_out",   64'(out_a), 64'hF);
        check("rst_al_vld",   64'(vld_a), 64'h0);
        check("rst_comb_out", 64'(out_c), 64'h20);
        check("rst_comb_vld", 64'(vld_c), 64'h1);

        // First edge after release loads the decode already on the inputs.
        @(negedge clk);
        rst = 1'b0;
        q.push_back(model(2'd2, 1'b1));

        for (int i = 0; i < 4; i++) drive(2'(i), 1'b1, 3'(i + 4), 1'b1);
        drive(2'bxx, 1'b0, 3'bxxx, 1'b0);
        drive(2'd3,  1'b0, 3'd7,   1'b0);
        drive(2'd1,  1'b1, 3'd5,   1'b1);
        drive(2'd0,  1'b0, 3'd0,   1'b0);
        drive(2'd2,  1'b1, 3'd2,   1'b1);

        // Reset between edges while out=0100.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out",    64'(out_d), 64'h0);
        check("mid_rst_vld",    64'(vld_d), 64'h0);
        check("mid_rst_al_out", 64'(out_a), 64'hF);
        @(negedge clk);
        in2 = 2'd3;
        en2 = 1'b1;
        rst = 1'b0;
        q.push_back(model(2'd3, 1'b1));

        repeat (300) begin
            re  = 1'($urandom_range(0, 1));
            rec = 1'($urandom_range(0, 1));
            ri  = 2'($urandom);
            rc  = 3'($urandom);
            if (!re && $urandom_range(0, 3) == 0) ri = 2'bxx;
            if (!rec && $urandom_range(0, 3) == 0) rc = 3'bxxx;
            drive(ri, re, rc, rec);
        end

        @(posedge clk);
        #2;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
